// File: rtl/tb_mem_arbiter_pkg.sv
// Shared types for the testbench RAM arbiter.
//   req_id_e    : which OBI port a RAM access belongs to
//   resp_tag_t  : per-access tag carried alongside the RAM read latency
package tb_mem_arbiter_pkg;

  typedef enum logic {
    REQ_INSTR = 1'b0,
    REQ_DATA  = 1'b1
  } req_id_e;

  typedef struct packed {
    logic    valid;
    req_id_e id;
    logic    is_write;
  } resp_tag_t;

  localparam int unsigned MAX_MEM_LATENCY = 4;
  localparam int unsigned TagWidth        = $bits(resp_tag_t);

endpackage

// File: rtl/tb_mem_resp_pipe.sv
// Fixed-depth shift register of response tags, matching the RAM read latency.
//   clk_i  : clock
//   rst_i  : asynchronous active-high reset, clears every stage (valid = 0)
//   tag_i  : tag of the access granted this cycle (valid = 0 for a bubble)
//   tag_o  : tag whose RAM data is on mem_rdata_i this cycle
module tb_mem_resp_pipe
  import tb_mem_arbiter_pkg::*;
#(
  parameter int unsigned Depth = 1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [TagWidth-1:0] tag_i,
  output logic [TagWidth-1:0] tag_o
);

  logic [Depth-1:0][TagWidth-1:0] stage_q, stage_d;

  if (Depth == 1) begin : g_single
    assign stage_d = tag_i;
  end else begin : g_multi
    assign stage_d = {stage_q[Depth-2:0], tag_i};
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stage_q <= '0;
    end else begin
      stage_q <= stage_d;
    end
  end

  assign tag_o = stage_q[Depth-1];

endmodule

// File: rtl/tb_mem_arbiter.sv
// Round-robin arbiter sharing one single-port RAM between instruction-fetch and
// data OBI ports. Grants are combinational; responses come back MEM_LATENCY
// cycles after the grant, routed by a tag pipeline.
//   clk_i, rst_i            : clock, asynchronous active-high reset
//   instr_req/addr_i        : fetch request;  instr_gnt/rvalid/rdata_o response
//   data_req/addr/we/be/wdata_i : data request; data_gnt/rvalid/rdata_o response
//   mem_en/we/be/addr/wdata_o   : RAM command;  mem_rdata_i RAM read data
module tb_mem_arbiter
  import tb_mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 22,
  parameter int unsigned MEM_LATENCY = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  instr_req_i,
  input  logic [31:0]           instr_addr_i,
  output logic                  instr_gnt_o,
  output logic                  instr_rvalid_o,
  output logic [31:0]           instr_rdata_o,
  input  logic                  data_req_i,
  input  logic [31:0]           data_addr_i,
  input  logic                  data_we_i,
  input  logic [3:0]            data_be_i,
  input  logic [31:0]           data_wdata_i,
  output logic                  data_gnt_o,
  output logic                  data_rvalid_o,
  output logic [31:0]           data_rdata_o,
  output logic                  mem_en_o,
  output logic                  mem_we_o,
  output logic [3:0]            mem_be_o,
  output logic [ADDR_WIDTH-3:0] mem_addr_o,
  output logic [31:0]           mem_wdata_o,
  input  logic [31:0]           mem_rdata_i
);

  if (MEM_LATENCY < 1 || MEM_LATENCY > MAX_MEM_LATENCY) begin : g_latency_check
    $error("MEM_LATENCY must be in 1..%0d", MAX_MEM_LATENCY);
  end

  req_id_e   last_q, last_d;
  logic      gnt_instr, gnt_data;
  logic      rsp_instr, rsp_data;
  resp_tag_t tag_in, tag_out;

  // Upper address bits alias and the low two bits are byte offsets.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{instr_addr_i, data_addr_i};

  // Arbitration: a lone requester always wins; on a tie the port that did not
  // win last time is served. Nothing is granted while reset is held.
  always_comb begin
    gnt_instr = 1'b0;
    gnt_data  = 1'b0;
    if (!rst_i) begin
      if (instr_req_i && data_req_i) begin
        gnt_data  = (last_q == REQ_INSTR);
        gnt_instr = (last_q == REQ_DATA);
      end else begin
        gnt_instr = instr_req_i;
        gnt_data  = data_req_i;
      end
    end
  end

  always_comb begin
    last_d = last_q;
    if (gnt_data) begin
      last_d = REQ_DATA;
    end else if (gnt_instr) begin
      last_d = REQ_INSTR;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      last_q <= REQ_INSTR;
    end else begin
      last_q <= last_d;
    end
  end

  assign instr_gnt_o = gnt_instr;
  assign data_gnt_o  = gnt_data;

  // RAM command mux; all fields are zero when idle.
  always_comb begin
    mem_en_o    = gnt_instr | gnt_data;
    mem_we_o    = 1'b0;
    mem_be_o    = 4'h0;
    mem_addr_o  = '0;
    mem_wdata_o = 32'h0;
    if (gnt_data) begin
      mem_we_o    = data_we_i;
      mem_be_o    = data_be_i;
      mem_addr_o  = data_addr_i[ADDR_WIDTH-1:2];
      mem_wdata_o = data_wdata_i;
    end else if (gnt_instr) begin
      mem_be_o    = 4'hF;
      mem_addr_o  = instr_addr_i[ADDR_WIDTH-1:2];
    end
  end

  always_comb begin
    tag_in          = '0;
    tag_in.valid    = gnt_instr | gnt_data;
    tag_in.id       = gnt_data ? REQ_DATA : REQ_INSTR;
    tag_in.is_write = gnt_data & data_we_i;
  end

  tb_mem_resp_pipe #(
    .Depth (MEM_LATENCY)
  ) u_resp_pipe (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .tag_i (tag_in),
    .tag_o (tag_out)
  );

  // The tag at the end of the pipe owns this cycle's RAM read data.
  always_comb begin
    rsp_instr      = tag_out.valid && (tag_out.id == REQ_INSTR);
    rsp_data       = tag_out.valid && (tag_out.id == REQ_DATA);
    instr_rvalid_o = rsp_instr;
    data_rvalid_o  = rsp_data;
    instr_rdata_o  = rsp_instr ? mem_rdata_i : 32'h0;
    data_rdata_o   = (rsp_data && !tag_out.is_write) ? mem_rdata_i : 32'h0;
  end

endmodule

// File: tb/tb_tb_mem_arbiter.sv
// Directed bench for tb_mem_arbiter: one instance with MEM_LATENCY=1 and one
// with MEM_LATENCY=3 share the same request stimulus, each with its own RAM.
module tb_tb_mem_arbiter;

  localparam int unsigned RamWords = 4096;
  localparam logic [1:0]  RspNone  = 2'd0;
  localparam logic [1:0]  RspI     = 2'd1;
  localparam logic [1:0]  RspD     = 2'd2;
  localparam int          NumVecs  = 19;

  typedef struct {
    logic        i_req;
    logic [31:0] i_addr;
    logic        d_req;
    logic [31:0] d_addr;
    logic        d_we;
    logic [3:0]  d_be;
    logic [31:0] d_wdata;
    logic        e_ig;
    logic        e_dg;
    logic [1:0]  e_rsp;   // response expected this cycle at latency 1
    logic [31:0] e_rdata;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        do_init;
  logic        i_req, d_req, d_we;
  logic [31:0] i_addr, d_addr, d_wdata;
  logic [3:0]  d_be;

  logic        ig1, irv1, dg1, drv1, men1, mwe1;
  logic [31:0] ird1, drd1, mwd1, mrd1;
  logic [3:0]  mbe1;
  logic [19:0] maddr1;
  logic        ig3, irv3, dg3, drv3, men3, mwe3;
  logic [31:0] ird3, drd3, mwd3, mrd3;
  logic [3:0]  mbe3;
  logic [19:0] maddr3;

  logic [31:0] ram1 [RamWords];
  logic [31:0] ram3 [RamWords];
  logic [31:0] rd1_q;
  logic [31:0] rd3_q [3];

  int n_pass  = 0;
  int n_total = 0;
  vec_t vecs [NumVecs];

  always #5 clk = ~clk;

  tb_mem_arbiter #(.ADDR_WIDTH(22), .MEM_LATENCY(1)) u_dut1 (
    .clk_i(clk), .rst_i(rst),
    .instr_req_i(i_req), .instr_addr_i(i_addr), .instr_gnt_o(ig1),
    .instr_rvalid_o(irv1), .instr_rdata_o(ird1),
    .data_req_i(d_req), .data_addr_i(d_addr), .data_we_i(d_we), .data_be_i(d_be),
    .data_wdata_i(d_wdata), .data_gnt_o(dg1), .data_rvalid_o(drv1), .data_rdata_o(drd1),
    .mem_en_o(men1), .mem_we_o(mwe1), .mem_be_o(mbe1), .mem_addr_o(maddr1),
    .mem_wdata_o(mwd1), .mem_rdata_i(mrd1)
  );

  tb_mem_arbiter #(.ADDR_WIDTH(22), .MEM_LATENCY(3)) u_dut3 (
    .clk_i(clk), .rst_i(rst),
    .instr_req_i(i_req), .instr_addr_i(i_addr), .instr_gnt_o(ig3),
    .instr_rvalid_o(irv3), .instr_rdata_o(ird3),
    .data_req_i(d_req), .data_addr_i(d_addr), .data_we_i(d_we), .data_be_i(d_be),
    .data_wdata_i(d_wdata), .data_gnt_o(dg3), .data_rvalid_o(drv3), .data_rdata_o(drd3),
    .mem_en_o(men3), .mem_we_o(mwe3), .mem_be_o(mbe3), .mem_addr_o(maddr3),
    .mem_wdata_o(mwd3), .mem_rdata_i(mrd3)
  );

  function automatic logic [31:0] init_word(input int i);
    if (i == 32'h60) return 32'h0000_0013;
    if (i == 32'h400) return 32'h0;
    return 32'hA000_0000 | 32'(i);
  endfunction

  // RAM models: write cycles return garbage so the arbiter must zero write responses.
  always @(posedge clk) begin
    if (do_init) begin
      for (int i = 0; i < RamWords; i++) begin
        ram1[i] <= init_word(i);
        ram3[i] <= init_word(i);
      end
    end else begin
      for (int b = 0; b < 4; b++) begin
        if (men1 && mwe1 && mbe1[b]) ram1[maddr1[11:0]][8*b +: 8] <= mwd1[8*b +: 8];
        if (men3 && mwe3 && mbe3[b]) ram3[maddr3[11:0]][8*b +: 8] <= mwd3[8*b +: 8];
      end
    end
    rd1_q    <= !men1 ? 32'h0 : mwe1 ? 32'hBAD0_BAD0 : ram1[maddr1[11:0]];
    rd3_q[0] <= !men3 ? 32'h0 : mwe3 ? 32'hBAD0_BAD0 : ram3[maddr3[11:0]];
    rd3_q[1] <= rd3_q[0];
    rd3_q[2] <= rd3_q[1];
  end

  assign mrd1 = rd1_q;
  assign mrd3 = rd3_q[2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  function automatic vec_t mk(input logic ir, input logic [31:0] ia, input logic dr,
                              input logic [31:0] da, input logic we, input logic [3:0] be,
                              input logic [31:0] wd, input logic eig, input logic edg,
                              input logic [1:0] rsp, input logic [31:0] rdata);
    vec_t v;
    v.i_req = ir; v.i_addr = ia; v.d_req = dr; v.d_addr = da; v.d_we = we;
    v.d_be = be; v.d_wdata = wd; v.e_ig = eig; v.e_dg = edg; v.e_rsp = rsp;
    v.e_rdata = rdata;
    return v;
  endfunction

  task automatic drive(input logic ir, input logic [31:0] ia, input logic dr,
                       input logic [31:0] da, input logic we, input logic [3:0] be,
                       input logic [31:0] wd);
    i_req = ir; i_addr = ia; d_req = dr; d_addr = da; d_we = we; d_be = be; d_wdata = wd;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_t v, v3;
    logic [31:0] e_be, e_addr, e_wd;
    logic [1:0]  rsp3;
    logic [31:0] rdata3;

    // Fetch 0x180, then 8 tie cycles, a partial write, and a burst of data reads.
    vecs[0]  = mk(1, 32'h180, 0, 32'h0,    0, 4'hF, 32'h0,       1, 0, RspNone, 32'h0);
    vecs[1]  = mk(0, 32'h0,   0, 32'h0,    0, 4'hF, 32'h0,       0, 0, RspI, 32'h0000_0013);
    vecs[2]  = mk(1, 32'h184, 1, 32'h0,    0, 4'hF, 32'h5A5A5A5A, 0, 1, RspNone, 32'h0);
    vecs[3]  = mk(1, 32'h184, 1, 32'h4,    0, 4'hF, 32'h5A5A5A5A, 1, 0, RspD, 32'hA000_0000);
    vecs[4]  = mk(1, 32'h188, 1, 32'h4,    0, 4'hF, 32'h5A5A5A5A, 0, 1, RspI, 32'hA000_0061);
    vecs[5]  = mk(1, 32'h188, 1, 32'h8,    0, 4'hF, 32'h5A5A5A5A, 1, 0, RspD, 32'hA000_0001);
    vecs[6]  = mk(1, 32'h18C, 1, 32'h8,    0, 4'hF, 32'h5A5A5A5A, 0, 1, RspI, 32'hA000_0062);
    vecs[7]  = mk(1, 32'h18C, 1, 32'hC,    0, 4'hF, 32'h5A5A5A5A, 1, 0, RspD, 32'hA000_0002);
    vecs[8]  = mk(1, 32'h190, 1, 32'hC,    0, 4'hF, 32'h5A5A5A5A, 0, 1, RspI, 32'hA000_0063);
    vecs[9]  = mk(1, 32'h190, 1, 32'h10,   0, 4'hF, 32'h5A5A5A5A, 1, 0, RspD, 32'hA000_0003);
    vecs[10] = mk(0, 32'h0,   1, 32'h1000, 1, 4'h3, 32'hDEADBEEF, 0, 1, RspI, 32'hA000_0064);
    vecs[11] = mk(0, 32'h0,   1, 32'h1000, 0, 4'hF, 32'h0,       0, 1, RspD, 32'h0);
    vecs[12] = mk(0, 32'h0,   1, 32'h0,    0, 4'hF, 32'h0,       0, 1, RspD, 32'h0000_BEEF);
    vecs[13] = mk(0, 32'h0,   1, 32'h4,    0, 4'hF, 32'h0,       0, 1, RspD, 32'hA000_0000);
    vecs[14] = mk(0, 32'h0,   1, 32'h8,    0, 4'hF, 32'h0,       0, 1, RspD, 32'hA000_0001);
    vecs[15] = mk(0, 32'h0,   0, 32'h0,    0, 4'hF, 32'h0,       0, 0, RspD, 32'hA000_0002);
    vecs[16] = mk(0, 32'h0,   0, 32'h0,    0, 4'hF, 32'h0,       0, 0, RspNone, 32'h0);
    vecs[17] = mk(0, 32'h0,   0, 32'h0,    0, 4'hF, 32'h0,       0, 0, RspNone, 32'h0);
    vecs[18] = mk(0, 32'h0,   0, 32'h0,    0, 4'hF, 32'h0,       0, 0, RspNone, 32'h0);

    // Reset with both requests active: everything must stay quiet.
    rst = 1'b1;
    do_init = 1'b1;
    drive(1, 32'h180, 1, 32'h4, 1, 4'hF, 32'hFFFF_FFFF);
    next_cycle();
    do_init = 1'b0;
    @(negedge clk);
    check("rst ig1", 32'(ig1), 32'h0);
    check("rst dg1", 32'(dg1), 32'h0);
    check("rst ig3", 32'(ig3), 32'h0);
    check("rst dg3", 32'(dg3), 32'h0);
    check("rst mem_en", 32'(men1), 32'h0);
    check("rst mem_addr", 32'(maddr1), 32'h0);
    check("rst mem_wdata", mwd1, 32'h0);
    check("rst mem_be", 32'(mbe1), 32'h0);
    check("rst rvalid", 32'({irv1, drv1, irv3, drv3}), 32'h0);
    check("rst rdata", ird1 | drd1 | ird3 | drd3, 32'h0);
    next_cycle();
    rst = 1'b0;

    for (int r = 0; r < NumVecs; r++) begin
      v = vecs[r];
      drive(v.i_req, v.i_addr, v.d_req, v.d_addr, v.d_we, v.d_be, v.d_wdata);
      @(negedge clk);
      e_be   = v.e_dg ? 32'(v.d_be) : v.e_ig ? 32'hF : 32'h0;
      e_addr = v.e_dg ? 32'(v.d_addr[21:2]) : v.e_ig ? 32'(v.i_addr[21:2]) : 32'h0;
      e_wd   = v.e_dg ? v.d_wdata : 32'h0;
      check($sformatf("r%0d ig1", r), 32'(ig1), 32'(v.e_ig));
      check($sformatf("r%0d dg1", r), 32'(dg1), 32'(v.e_dg));
      check($sformatf("r%0d ig3", r), 32'(ig3), 32'(v.e_ig));
      check($sformatf("r%0d dg3", r), 32'(dg3), 32'(v.e_dg));
      check($sformatf("r%0d mem_en", r), 32'(men1), 32'(v.e_ig | v.e_dg));
      check($sformatf("r%0d mem_we", r), 32'(mwe1), 32'(v.e_dg & v.d_we));
      check($sformatf("r%0d mem_be", r), 32'(mbe1), e_be);
      check($sformatf("r%0d mem_addr", r), 32'(maddr1), e_addr);
      check($sformatf("r%0d mem_wdata", r), mwd1, e_wd);
      check($sformatf("r%0d irv1", r), 32'(irv1), 32'(v.e_rsp == RspI));
      check($sformatf("r%0d drv1", r), 32'(drv1), 32'(v.e_rsp == RspD));
      check($sformatf("r%0d ird1", r), ird1, (v.e_rsp == RspI) ? v.e_rdata : 32'h0);
      check($sformatf("r%0d drd1", r), drd1, (v.e_rsp == RspD) ? v.e_rdata : 32'h0);
      // Latency 3 sees the latency-1 response two cycles later.
      rsp3 = RspNone;
      rdata3 = 32'h0;
      if (r >= 2) begin
        v3 = vecs[r-2];
        rsp3 = v3.e_rsp;
        rdata3 = v3.e_rdata;
      end
      check($sformatf("r%0d irv3", r), 32'(irv3), 32'(rsp3 == RspI));
      check($sformatf("r%0d drv3", r), 32'(drv3), 32'(rsp3 == RspD));
      check($sformatf("r%0d ird3", r), ird3, (rsp3 == RspI) ? rdata3 : 32'h0);
      check($sformatf("r%0d drd3", r), drd3, (rsp3 == RspD) ? rdata3 : 32'h0);
      next_cycle();
    end

    // Two grants (aliased fetch, then data), reset one cycle later: no responses survive.
    drive(1, 32'h0040_0180, 0, 32'h0, 0, 4'hF, 32'h0);
    @(negedge clk);
    check("mr ig3", 32'(ig3), 32'h1);
    check("mr alias addr", 32'(maddr1), 32'h60);
    next_cycle();
    drive(0, 32'h0, 1, 32'h0, 0, 4'hF, 32'h0);
    @(negedge clk);
    check("mr dg3", 32'(dg3), 32'h1);
    next_cycle();
    drive(0, 32'h0, 0, 32'h0, 0, 4'hF, 32'h0);
    rst = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      check($sformatf("mr rst%0d rvalid", c), 32'({irv1, drv1, irv3, drv3}), 32'h0);
      next_cycle();
    end
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check($sformatf("mr post%0d rvalid", c), 32'({irv1, drv1, irv3, drv3}), 32'h0);
      next_cycle();
    end

    // First tie after reset goes to data.
    drive(1, 32'h180, 1, 32'h0, 0, 4'hF, 32'h0);
    @(negedge clk);
    check("tie ig1", 32'(ig1), 32'h0);
    check("tie dg1", 32'(dg1), 32'h1);
    check("tie ig3", 32'(ig3), 32'h0);
    check("tie dg3", 32'(dg3), 32'h1);
    next_cycle();
    drive(0, 32'h0, 0, 32'h0, 0, 4'hF, 32'h0);
    @(negedge clk);
    check("tie drv1", 32'(drv1), 32'h1);
    check("tie drd1", drd1, 32'hA000_0000);
    check("tie irv1", 32'(irv1), 32'h0);
    next_cycle();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/tb_mem_arbiter.md
# tb_mem_arbiter

Arbiter that shares one single-port testbench RAM between the core's instruction-fetch and data OBI ports inside the core testbench subsystem. It grants at most one request per cycle with round-robin fairness and drives the RAM. It returns read data and write acknowledges to the correct requester after a fixed, parameterised RAM latency. It replaces a dual-port RAM model when single-port contention behaviour has to be exercised.

## Interface

Parameters:
- ADDR_WIDTH, 22, byte-address bits used for RAM indexing; RAM word address = addr[ADDR_WIDTH-1:2].
- MEM_LATENCY, 1, cycles from RAM enable to valid mem_rdata_i; legal range 1..4.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- instr_req_i  in  1  fetch request.
- instr_addr_i  in  32  fetch byte address.
- instr_gnt_o  out  1  fetch request accepted this cycle.
- instr_rvalid_o  out  1  fetch response valid.
- instr_rdata_o  out  32  fetch read data.
- data_req_i  in  1  data request.
- data_addr_i  in  32  data byte address.
- data_we_i  in  1  1 = write.
- data_be_i  in  4  byte enables.
- data_wdata_i  in  32  write data.
- data_gnt_o  out  1  data request accepted.
- data_rvalid_o  out  1  data response valid (reads and writes).
- data_rdata_o  out  32  data read data; 0 on write responses.
- mem_en_o  out  1  RAM access this cycle.
- mem_we_o  out  1  RAM write.
- mem_be_o  out  4  RAM byte enables.
- mem_addr_o  out  ADDR_WIDTH-2  RAM word address.
- mem_wdata_o  out  32  RAM write data.
- mem_rdata_i  in  32  RAM read data, MEM_LATENCY cycles after mem_en_o.

## Operation

- Grant logic is combinational from the request inputs and the priority register.
  - Only one requester active: that requester is granted.
  - Both active: the requester that does not own the priority register is granted.
  - gnt is asserted in the same cycle as req.
- Priority register `last` holds the last granted requester. It updates on every grant. Reset value is INSTR, so data wins the first tie.
- A granted request drives the RAM combinationally in the same cycle:
  - mem_en_o = 1.
  - mem_we/be/wdata come from the data port when data is granted.
  - For a fetch grant, mem_we_o = 0, mem_be_o = 4'hF and mem_wdata_o = 0.
- Tag pipeline: MEM_LATENCY stages, each holding {valid, requester, is_write}. Stage 0 loads the grant every cycle; a bubble has valid = 0.
- The last stage drives the responses:
  - rvalid for the tagged requester.
  - rdata = mem_rdata_i for reads, 0 for writes.
  - The non-selected rvalid is 0.
- Requesters hold req, addr and related inputs stable until gnt. The arbiter never applies back-pressure beyond the grant, and any number of accesses may be outstanding.
- Addresses at or above 2^ADDR_WIDTH alias (upper bits are ignored). No error response exists.

## Timing

- Reset values:
  - All gnt, rvalid and mem_en_o outputs are 0 while rst_i is high.
  - rdata outputs and mem_* data fields are 0.
  - The tag pipeline is cleared and `last` is set to INSTR.
- Latency: a grant in cycle N gives rvalid in cycle N+MEM_LATENCY.
- Throughput: one access per cycle.
  - Both requesters continuously requesting: grants alternate D, I, D, I, ...
  - A single requester gets back-to-back grants.
- Responses on each port are delivered in grant order. At most one rvalid is asserted per cycle across both ports.
- Reset asserted mid-operation: in-flight tags are discarded and no rvalid is produced for them, even after reset release.
- A request that drops without being granted is legal. No state changes.

## Structure

- Package tb_mem_arbiter_pkg:
  - typedef enum logic {REQ_INSTR, REQ_DATA} req_id_e.
  - packed struct resp_tag_t {valid, req_id_e id, is_write}.
  - localparam MAX_MEM_LATENCY = 4.
- Sub-module tb_mem_resp_pipe: a parameterised MEM_LATENCY-deep shift register of resp_tag_t with async active-high reset.
- Top level: arbitration, RAM muxing and response demux.
- An elaboration-time check rejects MEM_LATENCY outside 1..4.

## Test plan

- Reset, then instr only: fetch to 0x180 with RAM word 0x60 = 0x00000013 → instr_gnt_o same cycle. With MEM_LATENCY=1, instr_rvalid_o is high one cycle later with rdata 0x00000013. data_rvalid_o stays 0 throughout.
- Both requesting every cycle for 8 cycles → grant order D,I,D,I,D,I,D,I. The rvalid sequence follows the same order, delayed by MEM_LATENCY. Run with MEM_LATENCY = 1 and 3.
- Data write 0xDEADBEEF to 0x1000 with be=4'b0011, then a read of 0x1000 → write response has rdata 0. The read returns 0x0000BEEF, assuming the RAM was pre-cleared.
- Back-to-back data reads to 0x0, 0x4 and 0x8 with instr idle → three consecutive grants. Three consecutive rvalids return the matching words in order.
- Assert rst_i one cycle after two grants with MEM_LATENCY=3 → no rvalid is asserted for either access. The first post-reset tie is granted to data.
